// File: rtl/echo_pkg.sv
// Shared constants, tags and state type for the echo repeat pipe.
//   TAG_W / PIPE_W : method tag width and pipe word width
//   TAG_*          : request and indication method tags
//   sat_inc16      : saturating 16-bit increment
package echo_pkg;

  localparam int unsigned TAG_W  = 16;
  localparam int unsigned PIPE_W = 144;

  localparam logic [TAG_W-1:0] TAG_SAY    = 16'd0;
  localparam logic [TAG_W-1:0] TAG_SETREP = 16'd1;
  localparam logic [TAG_W-1:0] TAG_HEARD  = 16'd0;

  typedef enum logic [0:0] {
    FRESH  = 1'b0,
    REPEAT = 1'b1
  } echo_out_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

endpackage

// File: rtl/echo_fifo.sv
// DEPTH-entry flop FIFO, no enq-to-first bypass.
//   clk, rst   : clock, synchronous active-high reset
//   enq        : write enq_data at tail (ignored when full)
//   deq        : drop head entry (ignored when empty)
//   first_c    : head entry, combinational mux of the storage array
//   level      : occupancy, registered
module echo_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     deq,
  output logic [WIDTH-1:0]         first_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             enq_ok;
  logic             deq_ok;

  assign enq_ok  = enq && (level != LVL_W'(DEPTH));
  assign deq_ok  = deq && (level != '0);
  assign first_c = mem[rptr];

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      mem[wptr] <= enq_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (enq_ok) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (deq_ok) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({enq_ok, deq_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/echo_repeat_pipe.sv
// Echo with repeat: buffers say() payloads and returns each one as heard()
// repeat+1 times on the indication pipe.
//   CLK, RST                      : clock, synchronous active-high reset
//   request_enq_ena / _v          : request word valid / packed word (tag in top 16 bits)
//   request_enq_rdy               : request accepted this cycle (combinational in tag)
//   indication_enq_ena / _v       : heard word valid / packed word (combinational)
//   indication_enq_rdy            : downstream can take a word
//   level                         : FIFO occupancy
//   drop_count                    : saturating count of unknown-tag requests
module echo_repeat_pipe
  import echo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REP_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   request_enq_ena,
  input  logic [PIPE_W-1:0]      request_enq_v,
  output logic                   request_enq_rdy,
  output logic                   indication_enq_ena,
  output logic [PIPE_W-1:0]      indication_enq_v,
  input  logic                   indication_enq_rdy,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_count
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] req_tag;
  logic             full_c;
  logic             empty_c;
  logic             req_fire;
  logic             say_fire;
  logic             setrep_fire;
  logic             drop_fire;
  logic [WIDTH-1:0] head;
  logic             deq_c;
  logic             unused_req_body;

  logic [REP_W-1:0] repeat_q;
  logic [REP_W-1:0] cur_rep_q;
  logic [REP_W-1:0] cur_rep_d;
  logic [REP_W-1:0] beat_q;
  logic [REP_W-1:0] beat_d;
  echo_out_state_t  state_q;
  echo_out_state_t  state_d;

  // Only the tag and low payload bits carry meaning; the rest of the body is ignored.
  assign unused_req_body = ^request_enq_v;

  // Request decode; a full FIFO only blocks say(), other tags always drain.
  assign req_tag         = request_enq_v[PIPE_W-1 -: TAG_W];
  assign full_c          = (level == LVL_W'(DEPTH));
  assign empty_c         = (level == '0);
  assign request_enq_rdy = (req_tag != TAG_SAY) || !full_c;
  assign req_fire        = request_enq_ena && request_enq_rdy;
  assign say_fire        = req_fire && (req_tag == TAG_SAY);
  assign setrep_fire     = req_fire && (req_tag == TAG_SETREP);
  assign drop_fire       = req_fire && (req_tag != TAG_SAY) && (req_tag != TAG_SETREP);

  echo_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .enq      (say_fire),
    .enq_data (request_enq_v[WIDTH-1:0]),
    .deq      (deq_c),
    .first_c  (head),
    .level    (level)
  );

  // Heard word: zero tag, zero pad, payload from the FIFO head.
  assign indication_enq_v = {TAG_HEARD, (PIPE_W-TAG_W)'(head)};

  // Repeat register and drop counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      repeat_q   <= '0;
      drop_count <= '0;
    end else begin
      if (setrep_fire) begin
        repeat_q <= request_enq_v[REP_W-1:0];
      end
      if (drop_fire) begin
        drop_count <= sat_inc16(drop_count);
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FRESH;
      cur_rep_q <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_rep_q <= cur_rep_d;
      beat_q    <= beat_d;
    end
  end

  // Output FSM next-state. The repeat count is latched on the first beat so a
  // later setRepeat cannot change a word already in flight.
  always_comb begin
    state_d            = state_q;
    cur_rep_d          = cur_rep_q;
    beat_d             = beat_q;
    deq_c              = 1'b0;
    indication_enq_ena = 1'b0;
    case (state_q)
      FRESH: begin
        indication_enq_ena = !empty_c && indication_enq_rdy;
        if (indication_enq_ena) begin
          if (repeat_q == '0) begin
            deq_c = 1'b1;
          end else begin
            cur_rep_d = repeat_q;
            beat_d    = REP_W'(1);
            state_d   = REPEAT;
          end
        end
      end
      REPEAT: begin
        indication_enq_ena = indication_enq_rdy;
        if (indication_enq_ena) begin
          if (beat_q == cur_rep_q) begin
            deq_c   = 1'b1;
            beat_d  = '0;
            state_d = FRESH;
          end else begin
            beat_d = beat_q + REP_W'(1);
          end
        end
      end
      default: begin
        state_d = FRESH;
      end
    endcase
  end

endmodule

// File: tb/tb_echo_repeat_pipe.sv
// Directed bench for echo_repeat_pipe with a scoreboard model of the output beats.
module tb_echo_repeat_pipe;

  logic          clk;
  logic          rst;
  logic          req_ena;
  logic [143:0]  req_v;
  logic          req_rdy;
  logic          ind_ena;
  logic [143:0]  ind_v;
  logic          ind_rdy;
  logic [2:0]    level;
  logic [15:0]   drop;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard: payloads awaiting output, plus beat model state.
  logic [31:0] q[$];
  logic [7:0]  m_rep;
  logic [7:0]  m_cnt;
  bit          m_fresh;
  logic [15:0] m_drop;

  echo_repeat_pipe #(
    .WIDTH (32),
    .DEPTH (4),
    .REP_W (8)
  ) dut (
    .CLK                (clk),
    .RST                (rst),
    .request_enq_ena    (req_ena),
    .request_enq_v      (req_v),
    .request_enq_rdy    (req_rdy),
    .indication_enq_ena (ind_ena),
    .indication_enq_v   (ind_v),
    .indication_enq_rdy (ind_rdy),
    .level              (level),
    .drop_count         (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, then step.
  task automatic cycle();
    logic [15:0] tag;
    logic        exp_ena;
    logic        exp_rdy;
    logic        req_fire;
    @(negedge clk);
    tag     = req_v[143:128];
    exp_ena = (q.size() != 0) && ind_rdy;
    exp_rdy = (tag != 16'd0) || (q.size() != 4);
    check("ind_ena",    144'(ind_ena), 144'(exp_ena));
    check("level",      144'(level),   144'(q.size()));
    check("drop_count", 144'(drop),    144'(m_drop));
    check("req_rdy",    144'(req_rdy), 144'(exp_rdy));
    if (exp_ena) begin
      check("heard", ind_v, {16'd0, 96'd0, q[0]});
      if (m_fresh) begin
        if (m_rep == 8'd0) begin
          void'(q.pop_front());
        end else begin
          m_cnt   = m_rep;
          m_fresh = 1'b0;
        end
      end else begin
        m_cnt = m_cnt - 8'd1;
        if (m_cnt == 8'd0) begin
          void'(q.pop_front());
          m_fresh = 1'b1;
        end
      end
    end
    req_fire = req_ena && exp_rdy;
    if (rst) begin
      q.delete();
      m_rep   = 8'd0;
      m_cnt   = 8'd0;
      m_fresh = 1'b1;
      m_drop  = 16'd0;
    end else if (req_fire) begin
      case (tag)
        16'd0:   q.push_back(req_v[31:0]);
        16'd1:   m_rep = req_v[7:0];
        default: if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] tag, input logic [31:0] val);
    req_ena = 1'b1;
    req_v   = {tag, 96'd0, val};
    cycle();
    req_ena = 1'b0;
    req_v   = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst     = 1'b1;
    req_ena = 1'b0;
    req_v   = '0;
    ind_rdy = 1'b1;
    m_rep   = 8'd0;
    m_cnt   = 8'd0;
    m_fresh = 1'b1;
    m_drop  = 16'd0;
    @(posedge clk);
    #1;
    // Reset state
    cycle();
    rst = 1'b0;
    idle(2);

    // Single say echoed on the next cycle, level back to 0
    send(16'd0, 32'h1234);
    idle(3);

    // setRepeat(2): A,A,A,B,B,B
    send(16'd1, 32'd2);
    send(16'd0, 32'hAAAA_0001);
    send(16'd0, 32'hBBBB_0002);
    idle(8);

    // Back-pressure: fill to DEPTH, full blocks say but not setRepeat
    send(16'd1, 32'd0);
    ind_rdy = 1'b0;
    send(16'd0, 32'hC000_0000);
    send(16'd0, 32'hC000_0001);
    send(16'd0, 32'hC000_0002);
    send(16'd0, 32'hC000_0003);
    @(negedge clk);
    check("full_level", 144'(level),   144'(4));
    check("full_block", 144'(req_rdy), 144'(0));
    req_v = {16'd1, 96'd0, 32'd0};
    #1;
    check("setrep_rdy_when_full", 144'(req_rdy), 144'(1));
    req_v = '0;
    @(posedge clk);
    #1;
    send(16'd1, 32'd0);
    ind_rdy = 1'b1;
    idle(6);

    // setRepeat while a word is mid-repeat: A twice, B four times
    send(16'd1, 32'd1);
    send(16'd0, 32'hDDDD_000A);
    send(16'd1, 32'd3);
    send(16'd0, 32'hDDDD_000B);
    idle(8);

    // Random stalls during repeats lose nothing and add no beats
    send(16'd1, 32'd1);
    for (int i = 0; i < 24; i++) begin
      ind_rdy = 1'($urandom_range(0, 1));
      if (i < 3) send(16'd0, 32'hE000_0000 + 32'(i));
      else cycle();
    end
    ind_rdy = 1'b1;
    idle(8);

    // Unknown tag dropped, then saturation of the drop counter
    send(16'd7, 32'h5555);
    @(negedge clk);
    check("drop_one", 144'(drop), 144'(1));
    check("drop_no_heard", 144'(ind_ena), 144'(0));
    @(posedge clk);
    #1;
    req_ena = 1'b1;
    req_v   = {16'h0007, 128'd0};
    idle(65536);
    req_ena = 1'b0;
    req_v   = '0;
    cycle();
    @(negedge clk);
    check("drop_saturate", 144'(drop), 144'(16'hFFFF));
    @(posedge clk);
    #1;

    // Reset mid-REPEAT with three words queued; a same-cycle say is discarded
    send(16'd1, 32'd2);
    ind_rdy = 1'b0;
    send(16'd0, 32'hF000_0001);
    send(16'd0, 32'hF000_0002);
    send(16'd0, 32'hF000_0003);
    ind_rdy = 1'b1;
    cycle();
    rst     = 1'b1;
    req_ena = 1'b1;
    req_v   = {16'd0, 96'd0, 32'hF000_0004};
    cycle();
    rst     = 1'b0;
    req_ena = 1'b0;
    req_v   = '0;
    @(negedge clk);
    check("post_rst_ena",   144'(ind_ena), 144'(0));
    check("post_rst_level", 144'(level),   144'(0));
    check("post_rst_drop",  144'(drop),    144'(0));
    @(posedge clk);
    #1;
    send(16'd0, 32'hBEEF);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
